ram_stream_reader: RTL and testbench

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

---
 rtl/ram_pkg.sv | 11 +
 rtl/ram_rd_fifo.sv | 58 +++++
 rtl/ram_stream_reader.sv | 117 +++++++++++
 tb/tb_ram_stream_reader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared constants and FSM encoding for the RAM stream reader and its FIFO.
package ram_pkg;
  localparam int DWIDTH    = 32;
  localparam int BLOCLSIZE = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;
endpackage

// File: rtl/ram_rd_fifo.sv
// Two-entry read-data FIFO; slot 0 is always the head so the output is a plain register.
module ram_rd_fifo #(
  parameter int DWIDTH = ram_pkg::DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        count,
  output logic [DWIDTH-1:0] head
);
  logic [DWIDTH-1:0] slot0_q, slot0_d;
  logic [DWIDTH-1:0] slot1_q, slot1_d;
  logic [1:0]        count_q, count_d;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) slot0_d = push_data;
        else                 slot1_d = push_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop keeps the count; the new word lands behind any survivor.
        if (count_q == 2'd1) begin
          slot0_d = push_data;
        end else begin
          slot0_d = slot1_q;
          slot1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = slot0_q;
endmodule

// File: rtl/ram_stream_reader.sv
// Streams cmd_len words starting at cmd_addr (wrapping) out of a registered-read RAM
// port onto a valid/ready stream, throttling reads so the 2-entry FIFO never overflows.
module ram_stream_reader #(
  parameter int BLOCLSIZE = ram_pkg::BLOCLSIZE,
  parameter int DWIDTH    = ram_pkg::DWIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [BLOCLSIZE:0]   cmd_addr,
  input  logic [BLOCLSIZE+1:0] cmd_len,
  output logic [BLOCLSIZE:0]   r_addr,
  input  logic [DWIDTH-1:0]    r_dout,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DWIDTH-1:0]    m_data,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done
);
  import ram_pkg::*;

  localparam int AW = BLOCLSIZE + 1;
  localparam int LW = BLOCLSIZE + 2;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] remain_q, remain_d;
  logic [LW-1:0] beats_q, beats_d;
  logic [AW-1:0] r_addr_q;
  logic          inflight_q;
  logic          done_q, done_d;
  logic          accept;
  logic          issue;
  logic          pop;
  logic [1:0]    fifo_count;
  logic [2:0]    occupancy;

  assign accept  = cmd_valid && cmd_ready;
  assign m_valid = (fifo_count != 2'd0);
  assign pop     = m_valid && m_ready;
  assign m_last  = m_valid && (beats_q == LW'(1));
  assign done    = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && (cmd_len != '0)) state_d = ST_READ;
      ST_READ:  if (issue && (remain_q == LW'(1))) state_d = ST_DRAIN;
      ST_DRAIN: if (pop && m_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Reads are credited against FIFO space: buffered + in-flight words after this
  // cycle's pop must leave room for the word this issue will return.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = (state_q == ST_READ) && (occupancy < 3'd2);
    r_addr    = issue ? addr_q : r_addr_q;
  end

  always_comb begin
    addr_d   = addr_q;
    remain_d = remain_q;
    beats_d  = beats_q;
    if (accept) begin
      addr_d   = cmd_addr;
      remain_d = cmd_len;
      beats_d  = cmd_len;
    end else if (issue) begin
      addr_d   = addr_q + AW'(1);
      remain_d = remain_q - LW'(1);
    end
    if (pop) beats_d = beats_q - LW'(1);
    done_d = (accept && (cmd_len == '0)) || ((state_q == ST_DRAIN) && pop && m_last);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      remain_q   <= '0;
      beats_q    <= '0;
      r_addr_q   <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      beats_q    <= beats_d;
      r_addr_q   <= r_addr;
      inflight_q <= issue;
      done_q     <= done_d;
    end
  end

  // The word addressed in an issue cycle appears on r_dout one cycle later.
  ram_rd_fifo #(
    .DWIDTH(DWIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_data(r_dout),
    .pop      (pop),
    .count    (fifo_count),
    .head     (m_data)
  );
endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader driving a registered-read RAM model.
`timescale 1ns/1ps
module tb_ram_stream_reader;
  localparam int BL   = 10;
  localparam int AW   = BL + 1;
  localparam int LW   = BL + 2;
  localparam int DW   = 32;
  localparam int HIST = 4096;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr  = '0;
  logic [LW-1:0] cmd_len   = '0;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_dout    = '0;
  logic          m_valid;
  logic          m_ready   = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
  } beat_t;

  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            t_acc = 0;
  int            stall_err = 0;
  int            max_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  beat_t         beats_q[$];
  int            done_log[$];
  logic [AW-1:0] raddr_at [HIST];
  logic          busy_at [HIST];

  always #5 clk = ~clk;

  ram_stream_reader #(
    .BLOCLSIZE(BL),
    .DWIDTH   (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .r_addr   (r_addr),
    .r_dout   (r_dout),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .busy     (busy),
    .done     (done)
  );

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return {5'h1A, ~a, 5'h0D, a};
  endfunction

  // RAM model: registered read, data valid the cycle after the address.
  always @(posedge clk) r_dout <= ram_word(r_addr);
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < HIST) begin
      raddr_at[cyc] = r_addr;
      busy_at[cyc]  = busy;
    end
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && ((m_valid !== 1'b1) || (m_data !== prev_data))) stall_err++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (int'(dut.fifo_count) > max_cnt) max_cnt = int'(dut.fifo_count);
      if (m_valid && m_ready) beats_q.push_back('{m_data, m_last, cyc});
      if (done) done_log.push_back(cyc);
    end
  end

  function automatic logic [AW-1:0] raddr_hist(input int i);
    if (i >= 0 && i < HIST) return raddr_at[i];
    return 'x;
  endfunction

  function automatic logic busy_hist(input int i);
    if (i >= 0 && i < HIST) return busy_at[i];
    return 1'bx;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l, input string tag);
    int n;
    n = 0;
    beats_q.delete();
    done_log.delete();
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_accept_wait"}, 64'(n), 64'(0));
    tick();
    t_acc     = cyc;
    cmd_valid = 1'b0;
    $display("cmd %s: addr=0x%03h len=%0d accepted at cycle %0d", tag, a, l, t_acc);
  endtask

  task automatic run_until_done(input bit rnd, input int budget, input string tag);
    int n;
    n = 0;
    while (done_log.size() == 0 && n < budget) begin
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    m_ready = 1'b1;
    check({tag, "_timeout"}, 64'(n >= budget), 64'(0));
    tick();
    tick();
  endtask

  task automatic check_stream(input string tag, input logic [AW-1:0] a0, input int len,
                              input bit timed);
    int bad_data;
    int bad_last;
    int bad_cyc;
    int exp_done;
    bad_data = 0;
    bad_last = 0;
    bad_cyc  = 0;
    check({tag, "_beats"}, 64'(beats_q.size()), 64'(len));
    foreach (beats_q[i]) begin
      if (i < len) begin
        logic [AW-1:0] a;
        a = a0 + AW'(i);
        if (beats_q[i].data !== ram_word(a)) bad_data++;
        if (beats_q[i].last !== (i == len - 1)) bad_last++;
        if (beats_q[i].cyc != t_acc + 2 + i) bad_cyc++;
      end
    end
    check({tag, "_data_bad"}, 64'(bad_data), 64'(0));
    check({tag, "_last_bad"}, 64'(bad_last), 64'(0));
    if (timed) check({tag, "_bubble_bad"}, 64'(bad_cyc), 64'(0));
    check({tag, "_done_cnt"}, 64'(done_log.size()), 64'(1));
    if (timed) exp_done = t_acc + 2 + len;
    else       exp_done = (beats_q.size() > 0) ? beats_q[beats_q.size() - 1].cyc + 1 : -1;
    check({tag, "_done_cyc"}, 64'((done_log.size() > 0) ? done_log[0] : -2), 64'(exp_done));
  endtask

  initial begin
    logic [AW-1:0] exp2 [4];
    int n;
    int rel_cyc;
    exp2[0] = 11'h7FE;
    exp2[1] = 11'h7FF;
    exp2[2] = 11'h000;
    exp2[3] = 11'h001;

    // Reset values while rst is held low
    #2 rst = 1'b0;
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_r_addr",    64'(r_addr),    64'(0));
    check("rst_m_valid",   64'(m_valid),   64'(0));
    check("rst_m_last",    64'(m_last),    64'(0));
    check("rst_m_data",    64'(m_data),    64'(0));
    check("rst_busy",      64'(busy),      64'(0));
    check("rst_done",      64'(done),      64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Test 1: basic 4-word read, sink always ready
    send_cmd(11'h010, 12'd4, "t1");
    run_until_done(1'b0, 40, "t1");
    for (int i = 0; i < 4; i++)
      check($sformatf("t1_raddr%0d", i), 64'(raddr_hist(t_acc + i)), 64'(11'h010 + 11'(i)));
    check_stream("t1", 11'h010, 4, 1'b1);

    // Test 2: address wrap at the top of the RAM
    send_cmd(11'h7FE, 12'd4, "t2");
    run_until_done(1'b0, 40, "t2");
    for (int i = 0; i < 4; i++)
      check($sformatf("t2_raddr%0d", i), 64'(raddr_hist(t_acc + i)), 64'(exp2[i]));
    check_stream("t2", 11'h7FE, 4, 1'b1);

    // Test 3: random back-pressure
    send_cmd(11'h3F0, 12'd8, "t3");
    run_until_done(1'b1, 300, "t3");
    check_stream("t3", 11'h3F0, 8, 1'b0);
    check("t3_stall_unstable", 64'(stall_err), 64'(0));
    check("t3_fifo_max_le2",   64'(max_cnt <= 2), 64'(1));

    // Test 4: zero-length command
    send_cmd(11'h123, 12'd0, "t4");
    run_until_done(1'b0, 10, "t4");
    check("t4_raddr_hold0", 64'(raddr_hist(t_acc)),     64'(11'h3F7));
    check("t4_raddr_hold1", 64'(raddr_hist(t_acc + 1)), 64'(11'h3F7));
    check("t4_busy0",       64'(busy_hist(t_acc)),      64'(0));
    check("t4_busy1",       64'(busy_hist(t_acc + 1)),  64'(0));
    check("t4_done_cnt",    64'(done_log.size()),       64'(1));
    check("t4_done_cyc",    64'((done_log.size() > 0) ? done_log[0] : -1), 64'(t_acc));
    check("t4_beats",       64'(beats_q.size()),        64'(0));

    // Test 5: reset after the third beat of a 16-word command
    send_cmd(11'h200, 12'd16, "t5");
    n = 0;
    while (beats_q.size() < 3 && n < 40) begin
      tick();
      n++;
    end
    check("t5_wait_timeout", 64'(n >= 40), 64'(0));
    check("t5_beats_before_rst", 64'(beats_q.size()), 64'(3));
    rst = 1'b0;
    #1;
    check("t5_rst_m_valid",   64'(m_valid),   64'(0));
    check("t5_rst_m_last",    64'(m_last),    64'(0));
    check("t5_rst_busy",      64'(busy),      64'(0));
    check("t5_rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("t5_rst_r_addr",    64'(r_addr),    64'(0));
    check("t5_rst_m_data",    64'(m_data),    64'(0));
    check("t5_rst_done",      64'(done),      64'(0));
    tick();
    check("t5_rst_hold_m_valid", 64'(m_valid), 64'(0));
    rst = 1'b1;
    check("t5_no_done", 64'(done_log.size()), 64'(0));
    rel_cyc = cyc;
    send_cmd(11'h100, 12'd2, "t5b");
    check("t5b_first_edge_accept", 64'(t_acc), 64'(rel_cyc + 1));
    run_until_done(1'b0, 40, "t5b");
    check_stream("t5b", 11'h100, 2, 1'b1);

    // Test 6: full-RAM read from 0x005
    send_cmd(11'h005, 12'h800, "t6");
    run_until_done(1'b0, 2200, "t6");
    check_stream("t6", 11'h005, 2048, 1'b1);
    if (beats_q.size() > 0) begin
      check("t6_last_data", 64'(beats_q[beats_q.size() - 1].data), 64'(ram_word(11'h004)));
      check("t6_last_cyc",  64'(beats_q[beats_q.size() - 1].cyc - t_acc), 64'(2049));
    end
    check("t6_fifo_max_le2", 64'(max_cnt <= 2), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
